pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_defs.sv | 19 +
 rtl/pc_ras.sv | 48 ++++
 rtl/pc_sequencer.sv | 109 ++++++++++
 3 files changed

// File: rtl/pc_defs.sv
// Shared definitions for the PC sequencer: next-PC select encodings and
// the bit positions of the sticky status flags.
package pc_defs;

  typedef enum logic [2:0] {
    SRC_SEQ  = 3'd0,
    SRC_REL  = 3'd1,
    SRC_ABS  = 3'd2,
    SRC_CALL = 3'd3,
    SRC_RET  = 3'd4,
    SRC_BR   = 3'd5
  } pc_src_e;

  localparam int FLAG_OVF  = 0;
  localparam int FLAG_UNF  = 1;
  localparam int FLAG_ILL  = 2;
  localparam int NUM_FLAGS = 3;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a full push overwrites the oldest entry,
// and the depth counter saturates at DEPTH.
module pc_ras #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         push_data,
  output logic [WIDTH-1:0]         top,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] ONE_SP = AW'(1);
  localparam logic [AW:0]   ONE_D  = (AW+1)'(1);
  localparam logic [AW:0]   FULL_D = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    sp;

  // Entry storage is never reset; only the pointer and count are.
  always_ff @(posedge clk) begin
    if (push) mem[sp] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp    <= '0;
      depth <= '0;
    end else if (push) begin
      sp <= sp + ONE_SP;
      if (!full) depth <= depth + ONE_D;
    end else if (pop && !empty) begin
      sp    <= sp - ONE_SP;
      depth <= depth - ONE_D;
    end
  end

  assign top   = mem[sp - ONE_SP];
  assign full  = (depth == FULL_D);
  assign empty = (depth == '0);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: next-PC select, return-address stack and
// sticky error flags (RAS overflow/underflow, reserved select).
module pc_sequencer
  import pc_defs::*;
#(
  parameter int WIDTH        = 16,
  parameter int DEPTH        = 8,
  parameter int INC          = 2,
  parameter int RESET_VECTOR = 0
) (
  input  logic                     clock,
  input  logic                     pcReset_n,
  input  logic                     pcWrite,
  input  logic [2:0]               pcSrc,
  input  logic [WIDTH-1:0]         offset,
  input  logic [WIDTH-1:0]         target,
  input  logic                     comp,
  input  logic                     clrFlags,
  output logic [WIDTH-1:0]         pcCur,
  output logic [$clog2(DEPTH):0]   rasDepth,
  output logic                     rasOverflow,
  output logic                     rasUnderflow,
  output logic                     illegalSrc
);

  localparam logic [WIDTH-1:0] INC_W   = WIDTH'(INC);
  localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VECTOR);

  logic [WIDTH-1:0]     pc_seq;
  logic [WIDTH-1:0]     pc_rel;
  logic [WIDTH-1:0]     pc_next;
  logic [WIDTH-1:0]     ras_top;
  logic                 ras_full;
  logic                 ras_empty;
  logic                 push;
  logic                 pop;
  logic [NUM_FLAGS-1:0] flags;
  logic [NUM_FLAGS-1:0] flag_set;
  logic [NUM_FLAGS-1:0] flags_next;

  // Offset is two's complement; a plain WIDTH-bit add wraps identically.
  assign pc_seq = pcCur + INC_W;
  assign pc_rel = pcCur + offset;

  always_comb begin
    pc_next  = pcCur;
    push     = 1'b0;
    pop      = 1'b0;
    flag_set = '0;
    case (pcSrc)
      SRC_SEQ: pc_next = pc_seq;
      SRC_REL: pc_next = pc_rel;
      SRC_ABS: pc_next = target;
      SRC_CALL: begin
        pc_next            = target;
        push               = 1'b1;
        flag_set[FLAG_OVF] = ras_full;
      end
      SRC_RET: begin
        if (ras_empty) begin
          flag_set[FLAG_UNF] = 1'b1;
        end else begin
          pc_next = ras_top;
          pop     = 1'b1;
        end
      end
      SRC_BR:  pc_next = comp ? pc_rel : pc_seq;
      default: flag_set[FLAG_ILL] = 1'b1;
    endcase
    if (!pcWrite) begin
      push     = 1'b0;
      pop      = 1'b0;
      flag_set = '0;
    end
  end

  // Clear applies on every edge; a coincident set takes priority.
  assign flags_next = (clrFlags ? '0 : flags) | flag_set;

  always_ff @(posedge clock or negedge pcReset_n) begin
    if (!pcReset_n) begin
      pcCur <= RESET_W;
      flags <= '0;
    end else begin
      if (pcWrite) pcCur <= pc_next;
      flags <= flags_next;
    end
  end

  pc_ras #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ras (
    .clk       (clock),
    .rst_n     (pcReset_n),
    .push      (push),
    .pop       (pop),
    .push_data (pc_seq),
    .top       (ras_top),
    .depth     (rasDepth),
    .full      (ras_full),
    .empty     (ras_empty)
  );

  assign rasOverflow  = flags[FLAG_OVF];
  assign rasUnderflow = flags[FLAG_UNF];
  assign illegalSrc   = flags[FLAG_ILL];

endmodule
